// File: rtl/uart_acia.sv
// uart_acia: minimal 6850-style ACIA with an 8N1 transmitter/receiver oversampled 16x on CLKX4.
// Optional build macro UART_CTS_EN adds an nCTS input that gates the start of transmit frames.
module uart_acia #(
    parameter int BAUD_DIV = 52
) (
    input  logic       CLKX4,
    input  logic       nRESET,
    input  logic       E,
    input  logic       ADDR0,
    input  logic       nCSUART,
    input  logic       nRD,
    input  logic       nWR,
    inout  wire  [7:0] DATA,
    input  logic       RXD,
`ifdef UART_CTS_EN
    input  logic       nCTS,
`endif
    output logic       TXD,
    output logic       nIRQ
);

    localparam logic [7:0] TICK_RELOAD = 8'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic       r_e, r_cs_n, r_rd_n, r_wr_n, r_addr0;
    logic [7:0] r_data;
    logic [7:0] r_tick_cnt;
    logic       r_rx_s1, r_rx_s2;
    logic [7:0] r_tdr, r_rdr;
    logic       r_tdre, r_rdrf, r_fe, r_ovrn, r_rie, r_tie, r_nirq, r_txd;
    state_t     r_tx_state, r_rx_state;
    logic [3:0] r_tx_ph, r_rx_ph;
    logic [2:0] r_tx_bit, r_rx_bit;
    logic [7:0] r_tx_shift, r_rx_shift;

    state_t     w_tx_next, w_rx_next;
    logic       w_commit, w_bus_wr, w_wr_ctl, w_wr_dat, w_rd_dat, w_mreset, w_clr;
    logic       w_tick, w_rxd, w_cts_ok, w_cts_bit, w_irq;
    logic       w_tx_bit_end, w_tx_load, w_txd;
    logic       w_rx_bit_end, w_rx_sample, w_rx_done;
    logic [7:0] w_rd_val;

    // Bus strobes are sampled one edge ahead; the commit fires on the E falling edge.
    always_ff @(posedge CLKX4) begin
        if (!nRESET) begin
            r_e     <= 1'b0;
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_addr0 <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_e     <= E;
            r_cs_n  <= nCSUART;
            r_rd_n  <= nRD;
            r_wr_n  <= nWR;
            r_addr0 <= ADDR0;
            r_data  <= DATA;
        end
    end

    assign w_commit = r_e & ~E;
    assign w_bus_wr = w_commit & ~r_cs_n & ~r_wr_n;
    assign w_wr_ctl = w_bus_wr & ~r_addr0;
    assign w_wr_dat = w_bus_wr & r_addr0;
    assign w_rd_dat = w_commit & ~r_cs_n & ~r_rd_n & r_addr0;
    assign w_mreset = w_wr_ctl & (r_data[1:0] == 2'b11);
    assign w_clr    = ~nRESET | w_mreset;
    assign w_rxd    = r_rx_s2;
    assign w_tick   = (r_tick_cnt == 8'd0);

    always_ff @(posedge CLKX4) begin
        if (w_clr) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= RXD;
            r_rx_s2 <= r_rx_s1;
        end
    end

`ifdef UART_CTS_EN
    logic r_cts_s1, r_cts_s2;

    always_ff @(posedge CLKX4) begin
        if (w_clr) begin
            r_cts_s1 <= 1'b1;
            r_cts_s2 <= 1'b1;
        end else begin
            r_cts_s1 <= nCTS;
            r_cts_s2 <= r_cts_s1;
        end
    end

    assign w_cts_ok  = ~r_cts_s2;
    assign w_cts_bit = ~r_cts_s2;
`else
    assign w_cts_ok  = 1'b1;
    assign w_cts_bit = 1'b0;
`endif

    // Free-running 16x tick; only reset or master reset realigns it.
    always_ff @(posedge CLKX4) begin
        if (w_clr || w_tick) begin
            r_tick_cnt <= TICK_RELOAD;
        end else begin
            r_tick_cnt <= r_tick_cnt - 8'd1;
        end
    end

    always_ff @(posedge CLKX4) begin
        if (w_clr) begin
            r_tx_state <= S_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    assign w_tx_bit_end = w_tick & (r_tx_ph == 4'd15);

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (!r_tdre && w_cts_ok) w_tx_next = S_START; else w_tx_next = S_IDLE;
            S_START: if (w_tx_bit_end) w_tx_next = S_DATA; else w_tx_next = S_START;
            S_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_next = S_STOP; else w_tx_next = S_DATA;
            S_STOP: begin
                if (w_tx_bit_end) begin
                    if (!r_tdre && w_cts_ok) w_tx_next = S_START; else w_tx_next = S_IDLE;
                end else begin
                    w_tx_next = S_STOP;
                end
            end
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_load = (w_tx_next == S_START) && (r_tx_state != S_START);
        case (r_tx_state)
            S_IDLE:  w_txd = 1'b1;
            S_START: w_txd = 1'b0;
            S_DATA:  w_txd = r_tx_shift[0];
            S_STOP:  w_txd = 1'b1;
            default: w_txd = 1'b1;
        endcase
    end

    // Loading the shifter restarts the bit phase so the start bit spans a full 16 ticks.
    always_ff @(posedge CLKX4) begin
        if (w_clr) begin
            r_tx_ph    <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
        end else begin
            r_txd <= w_txd;
            if (w_tx_load) begin
                r_tx_shift <= r_tdr;
                r_tx_ph    <= 4'd0;
                r_tx_bit   <= 3'd0;
            end else begin
                if (w_tick) r_tx_ph <= r_tx_ph + 4'd1;
                if (r_tx_state == S_DATA && w_tx_bit_end) begin
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge CLKX4) begin
        if (w_clr) begin
            r_rx_state <= S_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    assign w_rx_bit_end = w_tick & (r_rx_ph == 4'd15);

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE: if (!w_rxd) w_rx_next = S_START; else w_rx_next = S_IDLE;
            S_START: begin
                if (w_tick && r_rx_ph == 4'd7) begin
                    if (w_rxd) w_rx_next = S_IDLE; else w_rx_next = S_DATA;
                end else begin
                    w_rx_next = S_START;
                end
            end
            S_DATA:  if (w_rx_bit_end && r_rx_bit == 3'd7) w_rx_next = S_STOP; else w_rx_next = S_DATA;
            S_STOP:  if (w_rx_bit_end) w_rx_next = S_IDLE; else w_rx_next = S_STOP;
            default: w_rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rx_sample = (r_rx_state == S_DATA) & w_rx_bit_end;
        w_rx_done   = (r_rx_state == S_STOP) & w_rx_bit_end;
    end

    always_ff @(posedge CLKX4) begin
        if (w_clr) begin
            r_rx_ph    <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            if (w_rx_next != r_rx_state) r_rx_ph <= 4'd0;
            else if (w_tick) r_rx_ph <= r_rx_ph + 4'd1;
            if (w_rx_sample) begin
                r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

    // A data-read clear is scheduled first so a frame landing on the same edge still loads.
    always_ff @(posedge CLKX4) begin
        if (w_clr) begin
            r_tdr  <= 8'h00;
            r_tdre <= 1'b1;
            r_rdr  <= 8'h00;
            r_rdrf <= 1'b0;
            r_fe   <= 1'b0;
            r_ovrn <= 1'b0;
        end else begin
            if (w_wr_dat) begin
                r_tdr  <= r_data;
                r_tdre <= 1'b0;
            end else if (w_tx_load) begin
                r_tdre <= 1'b1;
            end
            if (w_rd_dat) begin
                r_rdrf <= 1'b0;
                r_fe   <= 1'b0;
                r_ovrn <= 1'b0;
            end
            if (w_rx_done) begin
                r_fe <= ~w_rxd;
                if (r_rdrf && !w_rd_dat) begin
                    r_ovrn <= 1'b1;
                end else begin
                    r_rdr  <= r_rx_shift;
                    r_rdrf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLKX4) begin
        if (!nRESET) begin
            r_rie <= 1'b0;
            r_tie <= 1'b0;
        end else if (w_wr_ctl) begin
            r_rie <= r_data[7];
            r_tie <= r_data[5];
        end
    end

    assign w_irq = (r_rie & (r_rdrf | r_ovrn)) | (r_tie & r_tdre);

    always_ff @(posedge CLKX4) begin
        if (w_clr) begin
            r_nirq <= 1'b1;
        end else begin
            r_nirq <= ~w_irq;
        end
    end

    always_comb begin
        if (ADDR0) begin
            w_rd_val = r_rdr;
        end else begin
            w_rd_val = {w_irq, 1'b0, r_ovrn, r_fe, w_cts_bit, 1'b0, r_tdre, r_rdrf};
        end
    end

    assign DATA = (!nCSUART && !nRD) ? w_rd_val : 8'hzz;
    assign TXD  = r_txd;
    assign nIRQ = r_nirq;

endmodule

// File: tb/tb_uart_acia.sv
// tb_uart_acia: self-checking bench for uart_acia at BAUD_DIV=4 (64 CLKX4 cycles per bit), default build.
// A flag-level model of the ACIA plus a serial line decoder supply every expected value.
module tb_uart_acia;
    localparam int DIV  = 4;
    localparam int BITC = 16 * DIV;

    logic       CLKX4   = 1'b0;
    logic       nRESET  = 1'b0;
    logic       E       = 1'b0;
    logic       ADDR0   = 1'b0;
    logic       nCSUART = 1'b1;
    logic       nRD     = 1'b1;
    logic       nWR     = 1'b1;
    logic       RXD     = 1'b1;
    wire        TXD;
    wire        nIRQ;
    wire  [7:0] DATA;
    logic [7:0] tb_dout = 8'h00;
    logic       tb_drv  = 1'b0;

    assign DATA = tb_drv ? tb_dout : 8'hzz;

    uart_acia #(.BAUD_DIV(DIV)) dut (
        .CLKX4  (CLKX4),
        .nRESET (nRESET),
        .E      (E),
        .ADDR0  (ADDR0),
        .nCSUART(nCSUART),
        .nRD    (nRD),
        .nWR    (nWR),
        .DATA   (DATA),
        .RXD    (RXD),
        .TXD    (TXD),
        .nIRQ   (nIRQ)
    );

    always #5 CLKX4 = ~CLKX4;

    int cyc = 0;
    always @(posedge CLKX4) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // flag-level model of the register file
    logic       m_rdrf = 1'b0, m_fe = 1'b0, m_ovrn = 1'b0, m_tdre = 1'b1;
    logic       m_rie = 1'b0, m_tie = 1'b0;
    logic [7:0] m_rdr = 8'h00;

    logic [7:0] tx_exp[$];
    logic [7:0] tx_got[$];
    int         tx_start[$];
    int         tx_bad = 0;

    typedef struct {
        logic       is_wr;
        logic       addr;
        logic [7:0] wd;
        logic [7:0] exp_st;
        logic       exp_nirq;
    } vec_t;

    vec_t       vt[8];
    logic [7:0] d;
    int         gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        logic irq;
        irq = (m_rie & (m_rdrf | m_ovrn)) | (m_tie & m_tdre);
        return {irq, 1'b0, m_ovrn, m_fe, 1'b0, 1'b0, m_tdre, m_rdrf};
    endfunction

    // one CPU bus cycle; the commit happens on the edge after E drops
    task automatic bus(input logic wr, input logic a, input logic [7:0] wd, output logic [7:0] rd);
        @(negedge CLKX4);
        nCSUART = 1'b0;
        ADDR0   = a;
        E       = 1'b1;
        if (wr) begin
            nWR = 1'b0; tb_dout = wd; tb_drv = 1'b1;
        end else begin
            nRD = 1'b0;
        end
        @(negedge CLKX4);
        @(negedge CLKX4);
        rd = DATA;
        E  = 1'b0;
        @(negedge CLKX4);
        nCSUART = 1'b1; nRD = 1'b1; nWR = 1'b1; tb_drv = 1'b0;
    endtask

    task automatic ctl_write(input logic [7:0] v);
        logic [7:0] dummy;
        bus(1'b1, 1'b0, v, dummy);
        m_rie = v[7];
        m_tie = v[5];
        if (v[1:0] == 2'b11) begin
            m_rdrf = 1'b0; m_fe = 1'b0; m_ovrn = 1'b0; m_tdre = 1'b1; m_rdr = 8'h00;
        end
    endtask

    task automatic data_write(input logic [7:0] v);
        logic [7:0] dummy;
        bus(1'b1, 1'b1, v, dummy);
        tx_exp.push_back(v);
    endtask

    task automatic chk_status(input string name);
        logic [7:0] r;
        bus(1'b0, 1'b0, 8'h00, r);
        check(name, r, exp_status());
    endtask

    task automatic rd_data(input string name);
        logic [7:0] r;
        bus(1'b0, 1'b1, 8'h00, r);
        check(name, r, m_rdr);
        m_rdrf = 1'b0; m_fe = 1'b0; m_ovrn = 1'b0;
    endtask

    // drive one 8N1 frame; a bad stop bit is held low long enough to be sampled, then released
    task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
        @(negedge CLKX4);
        RXD = 1'b0;
        repeat (BITC) @(negedge CLKX4);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (BITC) @(negedge CLKX4);
        end
        if (stop_ok) begin
            RXD = 1'b1;
            repeat (BITC) @(negedge CLKX4);
        end else begin
            RXD = 1'b0;
            repeat (BITC * 3 / 4) @(negedge CLKX4);
            RXD = 1'b1;
            repeat (BITC / 4) @(negedge CLKX4);
        end
        if (m_rdrf) begin
            m_ovrn = 1'b1;
        end else begin
            m_rdr  = b;
            m_rdrf = 1'b1;
        end
        m_fe = ~stop_ok;
        repeat (8) @(negedge CLKX4);
    endtask

    task automatic wait_tx(input int n);
        int t;
        t = 0;
        while (tx_got.size() < n && t < 2000) begin
            @(negedge CLKX4);
            t++;
        end
        check("tx_frame_seen", (tx_got.size() >= n), 1'b1);
        for (int i = 0; i < n; i++) begin
            if (tx_got.size() > 0 && tx_exp.size() > 0) begin
                check("tx_byte", tx_got.pop_front(), tx_exp.pop_front());
            end
        end
    endtask

    // serial line decoder: samples TXD at mid-bit after each falling edge
    initial begin : tx_monitor
        logic [7:0] mb;
        logic       sb, pb;
        int         st;
        wait (nRESET === 1'b1);
        forever begin
            @(negedge CLKX4);
            if (TXD === 1'b0) begin
                st = cyc;
                repeat (BITC / 2) @(negedge CLKX4);
                sb = TXD;
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(negedge CLKX4);
                    mb[i] = TXD;
                end
                repeat (BITC) @(negedge CLKX4);
                pb = TXD;
                if (sb !== 1'b0 || pb !== 1'b1) tx_bad++;
                tx_got.push_back(mb);
                tx_start.push_back(st);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 60000", cyc);
        $fatal(1);
    end

    initial begin : main
        vt[0] = '{1'b1, 1'b0, 8'h80, 8'h02, 1'b1};
        vt[1] = '{1'b1, 1'b0, 8'h20, 8'h82, 1'b0};
        vt[2] = '{1'b1, 1'b0, 8'h00, 8'h02, 1'b1};
        vt[3] = '{1'b1, 1'b0, 8'hA0, 8'h82, 1'b0};
        vt[4] = '{1'b1, 1'b0, 8'h03, 8'h02, 1'b1};
        vt[5] = '{1'b1, 1'b0, 8'h23, 8'h82, 1'b0};
        vt[6] = '{1'b0, 1'b0, 8'h00, 8'h82, 1'b0};
        vt[7] = '{1'b1, 1'b0, 8'h00, 8'h02, 1'b1};

        nRESET = 1'b0;
        repeat (2) @(posedge CLKX4);
        @(negedge CLKX4);
        nRESET = 1'b1;
        check("rst_txd", TXD, 1'b1);
        check("rst_nirq", nIRQ, 1'b1);
        chk_status("rst_status");

        for (int i = 0; i < 8; i++) begin
            bus(vt[i].is_wr, vt[i].addr, vt[i].wd, d);
            repeat (3) @(negedge CLKX4);
            bus(1'b0, 1'b0, 8'h00, d);
            check($sformatf("vec%0d_status", i), d, vt[i].exp_st);
            check($sformatf("vec%0d_nirq", i), nIRQ, vt[i].exp_nirq);
        end

        data_write(8'h55);
        wait_tx(1);
        chk_status("tx55_idle_status");

        for (int i = 0; i < 3; i++) begin
            data_write(8'($urandom_range(0, 255)));
            wait_tx(1);
        end

        data_write(8'h01);
        repeat (100) @(negedge CLKX4);
        data_write(8'h80);
        m_tdre = 1'b0;
        chk_status("b2b_tdre_low");
        m_tdre = 1'b1;
        wait_tx(2);
        gap = (tx_start.size() >= 2) ? tx_start[tx_start.size() - 1] - tx_start[tx_start.size() - 2] : 0;
        checks++;
        if (gap < 9 * BITC + 15 * DIV + 1 || gap > 10 * BITC) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles expected %0d..%0d", gap, 9 * BITC + 15 * DIV + 1, 10 * BITC);
        end
        chk_status("b2b_idle_status");

        rx_frame(8'hA5, 1'b1);
        chk_status("rx_a5_status");
        rd_data("rx_a5_data");
        chk_status("rx_a5_cleared");

        for (int i = 0; i < 4; i++) begin
            rx_frame(8'($urandom_range(0, 255)), 1'b1);
            chk_status("rx_rand_status");
            rd_data("rx_rand_data");
        end

        RXD = 1'b0;
        repeat (12) @(negedge CLKX4);
        RXD = 1'b1;
        repeat (80) @(negedge CLKX4);
        chk_status("false_start_status");

        rx_frame(8'h3C, 1'b1);
        rx_frame(8'h7E, 1'b0);
        chk_status("err_status");
        rd_data("err_data");
        chk_status("err_cleared");

        ctl_write(8'h80);
        rx_frame(8'($urandom_range(0, 255)), 1'b1);
        repeat (3) @(negedge CLKX4);
        check("irq_rx_nirq", nIRQ, 1'b0);
        chk_status("irq_rx_status");
        rd_data("irq_rx_data");
        repeat (3) @(negedge CLKX4);
        check("irq_rx_clear_nirq", nIRQ, 1'b1);
        ctl_write(8'h20);
        repeat (3) @(negedge CLKX4);
        check("irq_tie_nirq", nIRQ, 1'b0);
        ctl_write(8'h00);
        repeat (3) @(negedge CLKX4);
        check("irq_off_nirq", nIRQ, 1'b1);

        bus(1'b1, 1'b1, 8'h00, d);
        repeat (300) @(negedge CLKX4);
        check("mr_txd_before", TXD, 1'b0);
        ctl_write(8'h03);
        check("mr_txd_now", TXD, 1'b1);
        repeat (100) @(negedge CLKX4);
        check("mr_txd_idle", TXD, 1'b1);
        chk_status("mr_status");
        repeat (800) @(negedge CLKX4);
        tx_got.delete();
        tx_start.delete();

        data_write(8'($urandom_range(0, 255)));
        wait_tx(1);
        check("tx_framing_errors", tx_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
